// File: rtl/ds2_device.sv
// DualShock2 controller-side link emulator: answers poll 0x42 on DAT with ACK pulses.
// Define DS2_DEVICE_ANALOG_EN for the analog pad (ID 0x73, 9 bytes); otherwise digital (ID 0x41, 5 bytes).
module ds2_device #(
  parameter int unsigned ACK_DELAY = 64,
  parameter int unsigned ACK_LEN   = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ds2_att,
  input  logic        ds2_clk,
  input  logic        ds2_cmd,
  output logic        ds2_dat,
  output logic        ds2_ack,
  input  logic [15:0] buttons,
  input  logic [7:0]  stick_rx,
  input  logic [7:0]  stick_ry,
  input  logic [7:0]  stick_lx,
  input  logic [7:0]  stick_ly,
  output logic        frame_done,
  output logic        busy
);

`ifdef DS2_DEVICE_ANALOG_EN
  localparam logic [7:0]  ID  = 8'h73;
  localparam int unsigned LEN = 9;
`else
  localparam logic [7:0]  ID  = 8'h41;
  localparam int unsigned LEN = 5;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_ACK_DLY, S_ACK, S_IGNORE, S_DONE
  } state_t;

  // [0],[1] synchronizer stages, [2] previous value for edge detection
  logic [2:0] att_sync_q;
  logic [2:0] clk_sync_q;
  logic [1:0] cmd_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      att_sync_q <= '1;
      clk_sync_q <= '1;
      cmd_sync_q <= '1;
    end else begin
      att_sync_q <= {att_sync_q[1:0], ds2_att};
      clk_sync_q <= {clk_sync_q[1:0], ds2_clk};
      cmd_sync_q <= {cmd_sync_q[0], ds2_cmd};
    end
  end

  logic att_fall, att_rise, clk_fall, clk_rise, cmd_bit;
  assign att_fall = att_sync_q[2] & ~att_sync_q[1];
  assign att_rise = ~att_sync_q[2] & att_sync_q[1];
  assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign clk_rise = ~clk_sync_q[2] & clk_sync_q[1];
  assign cmd_bit  = cmd_sync_q[1];

  state_t      state_q, state_d;
  logic [3:0]  byte_q, byte_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  rx_q, rx_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        dat_q, dat_d;
  logic        ack_q, ack_d;
  logic        done_q, done_d;
  logic [15:0] btn_q, btn_d;
  logic [7:0]  resp_byte;

`ifdef DS2_DEVICE_ANALOG_EN
  logic [31:0] stick_q, stick_d;
`else
  logic unused_sticks;
  assign unused_sticks = ^{stick_rx, stick_ry, stick_lx, stick_ly};
`endif

  always_comb begin
    resp_byte = 8'hFF;
    case (byte_q)
      4'd1: resp_byte = ID;
      4'd2: resp_byte = 8'h5A;
      4'd3: resp_byte = btn_q[7:0];
      4'd4: resp_byte = btn_q[15:8];
`ifdef DS2_DEVICE_ANALOG_EN
      4'd5: resp_byte = stick_q[7:0];
      4'd6: resp_byte = stick_q[15:8];
      4'd7: resp_byte = stick_q[23:16];
      4'd8: resp_byte = stick_q[31:24];
`endif
      default: resp_byte = 8'hFF;
    endcase
  end

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    ack_d   = ack_q;
    done_d  = 1'b0;
    btn_d   = btn_q;
`ifdef DS2_DEVICE_ANALOG_EN
    stick_d = stick_q;
`endif
    // ATT release aborts the frame from any state and beats any CLK edge
    if (att_rise) begin
      state_d = S_IDLE;
      byte_d  = '0;
      bit_d   = '0;
      cnt_d   = '0;
      dat_d   = 1'b1;
      ack_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          dat_d = 1'b1;
          ack_d = 1'b1;
          if (att_fall) begin
            state_d = S_SHIFT;
            byte_d  = '0;
            bit_d   = '0;
            btn_d   = ~buttons;
`ifdef DS2_DEVICE_ANALOG_EN
            stick_d = {stick_ly, stick_lx, stick_ry, stick_rx};
`endif
          end
        end
        S_SHIFT: begin
          if (clk_fall) dat_d = resp_byte[bit_q];
          if (clk_rise) begin
            rx_d[bit_q] = cmd_bit;
            bit_d       = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              cnt_d = '0;
              if ((byte_q == 4'd0 && rx_d != 8'h01) ||
                  (byte_q == 4'd1 && rx_d != 8'h42)) begin
                state_d = S_IGNORE;
                dat_d   = 1'b1;
              end else if (byte_q == 4'(LEN - 1)) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                dat_d   = 1'b1;
              end else begin
                state_d = S_ACK_DLY;
                byte_d  = byte_q + 4'd1;
              end
            end
          end
        end
        S_ACK_DLY, S_ACK: begin
          // an impatient host clocking the next byte cuts the ACK phase short
          if (clk_fall) begin
            state_d = S_SHIFT;
            ack_d   = 1'b1;
            dat_d   = resp_byte[bit_q];
            cnt_d   = '0;
          end else if (state_q == S_ACK_DLY && cnt_q == 10'(ACK_DELAY - 1)) begin
            state_d = S_ACK;
            ack_d   = 1'b0;
            cnt_d   = '0;
          end else if (state_q == S_ACK && cnt_q == 10'(ACK_LEN - 1)) begin
            state_d = S_SHIFT;
            ack_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
        S_IGNORE: begin
          dat_d = 1'b1;
          ack_d = 1'b1;
        end
        S_DONE: begin
          dat_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      byte_q  <= '0;
      bit_q   <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      dat_q   <= 1'b1;
      ack_q   <= 1'b1;
      done_q  <= 1'b0;
      btn_q   <= '0;
`ifdef DS2_DEVICE_ANALOG_EN
      stick_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      btn_q   <= btn_d;
`ifdef DS2_DEVICE_ANALOG_EN
      stick_q <= stick_d;
`endif
    end
  end

  assign ds2_dat    = dat_q;
  assign ds2_ack    = ack_q;
  assign frame_done = done_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ds2_device.sv
// Host-side bench for ds2_device: bit-bangs ATT/CLK/CMD frames and checks DAT/ACK against a frame model.
module tb_ds2_device;
  localparam int unsigned ACK_DELAY = 64;
  localparam int unsigned ACK_LEN   = 512;
`ifdef DS2_DEVICE_ANALOG_EN
  localparam int          LEN = 9;
  localparam logic [7:0]  ID  = 8'h73;
`else
  localparam int          LEN = 5;
  localparam logic [7:0]  ID  = 8'h41;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ds2_att = 1'b1, ds2_clk = 1'b1, ds2_cmd = 1'b1;
  logic        ds2_dat, ds2_ack, frame_done, busy;
  logic [15:0] buttons = '0;
  logic [7:0]  stick_rx = '0, stick_ry = '0, stick_lx = '0, stick_ly = '0;

  ds2_device #(.ACK_DELAY(ACK_DELAY), .ACK_LEN(ACK_LEN)) dut (
    .clk(clk), .rst(rst), .ds2_att(ds2_att), .ds2_clk(ds2_clk), .ds2_cmd(ds2_cmd),
    .ds2_dat(ds2_dat), .ds2_ack(ds2_ack), .buttons(buttons),
    .stick_rx(stick_rx), .stick_ry(stick_ry), .stick_lx(stick_lx), .stick_ly(stick_ly),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0;
  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame model state
  logic [7:0]  tx_b   [9];
  logic [7:0]  got_rx [9];
  logic [7:0]  exp_rx [9];
  logic [15:0] snap_btn;
  logic [7:0]  snap_stk [4];
  int          exp_acks;
  bit          exp_done;
  int          done_at_byte;

  // Expected host-side view of a frame from the snapshot and what the host sent
  function automatic void model(input int n);
    logic [7:0] resp [9];
    bit ign;
    resp[0] = 8'hFF; resp[1] = ID; resp[2] = 8'h5A;
    resp[3] = ~snap_btn[7:0]; resp[4] = ~snap_btn[15:8];
    for (int k = 0; k < 4; k++) resp[5 + k] = snap_stk[k];
    ign = 0; exp_acks = 0; exp_done = 0; done_at_byte = -1;
    for (int i = 0; i < n; i++) begin
      exp_rx[i] = ign ? 8'hFF : resp[i];
      if (!ign) begin
        if ((i == 0 && tx_b[0] != 8'h01) || (i == 1 && tx_b[1] != 8'h42)) ign = 1;
        else if (i == LEN - 1) begin exp_done = 1; done_at_byte = i; ign = 1; end
        else exp_acks++;
      end
    end
  endfunction

  task automatic run_frame(input int n, input int early_n, input int chg_byte,
                           input logic [15:0] chg_val, input int abort_byte);
    int unsigned t0, t_rise, fall;
    int acks, done0, k;
    bit seen, pre_fell;
    done0 = done_cnt;
    acks = 0;
    pre_fell = 0;
    for (int i = 0; i < 9; i++) got_rx[i] = 8'h00;
    snap_btn = buttons;
    snap_stk[0] = stick_rx; snap_stk[1] = stick_ry; snap_stk[2] = stick_lx; snap_stk[3] = stick_ly;
    model(n);
    ds2_att = 1'b0;
    t0 = cyc;
    tick(2);
    check("busy_pre", {31'd0, busy}, 32'd0);
    tick(1);
    check("busy_on", {31'd0, busy}, 32'd1);
    tick(6);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (b == 0 && pre_fell) tick(5);
        else begin
          ds2_clk = 1'b0;
          ds2_cmd = tx_b[i][b];
          tick(8);
        end
        if (i == chg_byte && b == 4) buttons = chg_val;
        got_rx[i][b] = ds2_dat;
        ds2_clk = 1'b1;
        if (i == abort_byte && b == 3) begin
          tick(8);
          ds2_att = 1'b1;
          tick(2);
          check("abort_busy_hold", {31'd0, busy}, 32'd1);
          tick(1);
          check("abort_dat", {31'd0, ds2_dat}, 32'd1);
          check("abort_ack", {31'd0, ds2_ack}, 32'd1);
          check("abort_busy", {31'd0, busy}, 32'd0);
          tick(20);
          check("abort_no_done", done_cnt - done0, 32'd0);
          for (int j = 0; j < i; j++) check("abort_rx", {24'd0, got_rx[j]}, {24'd0, exp_rx[j]});
          return;
        end
        if (b < 7) tick(8);
        else t_rise = cyc;
      end
      pre_fell = 0;
      seen = 0;
      for (int j = 1; j <= 100; j++) begin
        tick(1);
        if (j == 3) check("done_timing", {31'd0, frame_done}, {31'd0, (i == done_at_byte)});
        if (ds2_ack === 1'b0) begin seen = 1; break; end
      end
      if (seen) begin
        acks++;
        fall = cyc;
        check("ack_delay", cyc - t_rise, ACK_DELAY + 3);
        if (early_n > 0 && i < n - 1) begin
          tick(early_n);
          ds2_clk = 1'b0;
          ds2_cmd = tx_b[i + 1][0];
          pre_fell = 1;
          tick(2);
          check("ack_hold", {31'd0, ds2_ack}, 32'd0);
          tick(1);
          check("ack_early_rel", {31'd0, ds2_ack}, 32'd1);
        end else begin
          k = 0;
          while (ds2_ack !== 1'b1 && k < 700) begin tick(1); k++; end
          check("ack_len", cyc - fall, ACK_LEN);
        end
      end
    end
    tick(10);
    ds2_att = 1'b1;
    ds2_clk = 1'b1;
    tick(4);
    check("busy_off", {31'd0, busy}, 32'd0);
    check("idle_dat", {31'd0, ds2_dat}, 32'd1);
    for (int i = 0; i < n; i++) check("rx_byte", {24'd0, got_rx[i]}, {24'd0, exp_rx[i]});
    check("ack_count", acks, exp_acks);
    check("done_count", done_cnt - done0, {31'd0, exp_done});
    tick(6);
  endtask

  task automatic set_poll_tx();
    tx_b[0] = 8'h01; tx_b[1] = 8'h42;
    for (int i = 2; i < 9; i++) tx_b[i] = 8'h00;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("rst_dat", {31'd0, ds2_dat}, 32'd1);
    check("rst_ack", {31'd0, ds2_ack}, 32'd1);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick(5);

    // Reference poll with full-length ACKs
    buttons = 16'h0011;
    stick_rx = 8'h80; stick_ry = 8'h7F; stick_lx = 8'h00; stick_ly = 8'hFF;
    set_poll_tx();
    run_frame(LEN, 0, -1, '0, -1);

    // Snapshot stays fixed while buttons move mid-frame
    buttons = 16'h0000;
    run_frame(LEN, 150, 4, 16'hFFFF, -1);
    run_frame(LEN, 150, -1, '0, -1);

    // Bad header
    tx_b[0] = 8'h81;
    run_frame(LEN, 0, -1, '0, -1);

    // Unsupported command
    set_poll_tx();
    tx_b[1] = 8'h43;
    run_frame(LEN, 0, -1, '0, -1);

    // Abort mid-byte, then a clean frame
    set_poll_tx();
    buttons = 16'hA55A;
    run_frame(LEN, 120, -1, '0, (LEN > 5) ? 5 : 3);
    run_frame(LEN, 120, -1, '0, -1);

    // Early CLK after the ACK fall
    run_frame(LEN, 100, -1, '0, -1);

    // Randomized frames
    for (int r = 0; r < 6; r++) begin
      buttons  = 16'($urandom);
      stick_rx = 8'($urandom); stick_ry = 8'($urandom);
      stick_lx = 8'($urandom); stick_ly = 8'($urandom);
      set_poll_tx();
      for (int i = 2; i < 9; i++) tx_b[i] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) tx_b[$urandom_range(0, 1)] = 8'($urandom);
      run_frame(LEN, int'($urandom_range(5, 400)), -1, '0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
